// File: rtl/axis_boxcar_averager_if.sv
// AXI-Stream data channel: payload, valid, ready.
interface axis_boxcar_averager_if #(
  parameter int unsigned DataWidth = 32
);
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_boxcar_averager.sv
// Block-averaging decimator: sums 2^n signed samples and emits their floor mean on AXI-Stream.
module axis_boxcar_averager #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LOG2_MAX_N       = 10
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [$clog2(LOG2_MAX_N+1)-1:0]   cfg_log2n,
  axis_boxcar_averager_if.slave             s_axis,
  axis_boxcar_averager_if.master            m_axis,
  output logic [31:0]                       sts_blocks
);

  localparam int unsigned AccW = AXIS_TDATA_WIDTH + LOG2_MAX_N;
  localparam int unsigned CfgW = $clog2(LOG2_MAX_N + 1);
  localparam logic [CfgW-1:0] MaxN = CfgW'(LOG2_MAX_N);

  logic signed [AccW-1:0]       acc_q, acc_d;
  logic [LOG2_MAX_N-1:0]        cnt_q, cnt_d;
  logic [CfgW-1:0]              n_lat_q, n_lat_d;
  logic                         m_valid_q, m_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [31:0]                  sts_q, sts_d;

  logic [CfgW-1:0]              n_clamp, n_use;
  logic [LOG2_MAX_N-1:0]        ones, cnt_last;
  logic signed [AccW-1:0]       sample_ext, acc_sum, mean_full;
  logic                         s_ready, accept, closing;

  // Effective block size, closing index and the running sum including the current sample.
  always_comb begin
    n_clamp    = (cfg_log2n > MaxN) ? MaxN : cfg_log2n;
    // Block length is only sampled when a new block starts; mid-block changes wait.
    n_use      = (cnt_q == '0) ? n_clamp : n_lat_q;
    ones       = '1;
    cnt_last   = ~(ones << n_use);
    sample_ext = {{LOG2_MAX_N{s_axis.tdata[AXIS_TDATA_WIDTH-1]}}, s_axis.tdata};
    acc_sum    = acc_q + sample_ext;
    mean_full  = acc_sum >>> n_use;
    // Only the block-closing sample can be blocked, and only by an unaccepted mean.
    s_ready    = ~m_valid_q | m_axis.tready | (cnt_q != cnt_last);
    accept     = s_axis.tvalid & s_ready;
    closing    = accept & (cnt_q == cnt_last);
  end

  // Next-state: accumulate, close blocks, and track downstream acceptance.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_lat_d   = n_lat_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    sts_d     = sts_q;
    if (m_valid_q && m_axis.tready) begin
      m_valid_d = 1'b0;
      sts_d     = sts_q + 32'd1;
    end
    if (accept) begin
      if (cnt_q == '0) begin
        n_lat_d = n_clamp;
      end
      if (closing) begin
        // A mean produced in the same cycle as a handshake overrides the clear above.
        m_data_d  = mean_full[AXIS_TDATA_WIDTH-1:0];
        m_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any partial block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      n_lat_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sts_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      n_lat_q   <= n_lat_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      sts_q     <= sts_d;
    end
  end

  // Port drive.
  always_comb begin
    s_axis.tready = s_ready;
    m_axis.tvalid = m_valid_q;
    m_axis.tdata  = m_data_q;
    sts_blocks    = sts_q;
  end

endmodule

// File: tb/tb_axis_boxcar_averager.sv
// Scoreboard bench for axis_boxcar_averager: a behavioural model pushes expected means on
// every accepted closing sample; the output monitor pops and compares on each handshake.
module tb_axis_boxcar_averager;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  cfg_log2n = 4'd0;
  logic [31:0] sts_blocks;

  axis_boxcar_averager_if #(.DataWidth(32)) s_if ();
  axis_boxcar_averager_if #(.DataWidth(32)) m_if ();

  axis_boxcar_averager #(
    .AXIS_TDATA_WIDTH(32),
    .LOG2_MAX_N      (10)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .cfg_log2n (cfg_log2n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .sts_blocks(sts_blocks)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  longint      mdl_acc  = 0;
  int          mdl_cnt  = 0;
  int          mdl_n    = 0;
  bit          fullrate = 1'b0;
  int          stalls   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Input model and output monitor, both sampled on the falling edge.
  initial forever begin
    @(negedge aclk);
    if (areset) begin
      mdl_acc = 0;
      mdl_cnt = 0;
    end else begin
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
        else check_eq("mean", m_if.tdata, sb.pop_front());
      end
      if (s_if.tvalid && s_if.tready) begin
        if (mdl_cnt == 0) mdl_n = (cfg_log2n > 4'd10) ? 10 : int'(cfg_log2n);
        mdl_acc += longint'($signed(s_if.tdata));
        mdl_cnt++;
        if (mdl_cnt == (1 << mdl_n)) begin
          sb.push_back(32'(mdl_acc >>> mdl_n));
          mdl_acc = 0;
          mdl_cnt = 0;
        end
      end
      if (fullrate && s_if.tvalid && !s_if.tready) stalls++;
    end
  end

  // Present one sample and return just after the edge that accepts it (tvalid left high).
  task automatic send(input logic [31:0] d);
    int t = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    while (!s_if.tready && t < 200) begin
      t++;
      @(negedge aclk);
    end
    if (!s_if.tready) check_eq("tready_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    do_reset();
    check_eq("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check_eq("rst_tdata", m_if.tdata, 32'd0);
    check_eq("rst_sts", sts_blocks, 32'd0);
    check_eq("rst_tready", {31'd0, s_if.tready}, 32'd1);

    // 1: n=2, 1..4 back-to-back -> mean 2 one cycle after last accept.
    cfg_log2n = 4'd2;
    send(32'd1); send(32'd2); send(32'd3);
    check_eq("t1_no_early", {31'd0, m_if.tvalid}, 32'd0);
    send(32'd4);
    idle();
    check_eq("t1_valid", {31'd0, m_if.tvalid}, 32'd1);
    check_eq("t1_mean", m_if.tdata, 32'd2);
    step();
    check_eq("t1_sts", sts_blocks, 32'd1);
    check_eq("t1_drop", {31'd0, m_if.tvalid}, 32'd0);

    // 2: n=1, -3,-2 -> floor(-5/2) = -3.
    cfg_log2n = 4'd1;
    send(32'hFFFF_FFFD); send(32'hFFFF_FFFE);
    idle();
    check_eq("t2_mean", m_if.tdata, 32'hFFFF_FFFD);
    step();

    // 3: n=0 with downstream stalled: second sample blocked until the first mean drains.
    do_reset();
    cfg_log2n   = 4'd0;
    m_if.tready = 1'b0;
    send(32'd5);
    s_if.tdata = 32'd6;
    check_eq("t3_hold_valid", {31'd0, m_if.tvalid}, 32'd1);
    check_eq("t3_hold_data", m_if.tdata, 32'd5);
    repeat (2) begin
      @(negedge aclk);
      check_eq("t3_stall", {31'd0, s_if.tready}, 32'd0);
    end
    step();
    check_eq("t3_still5", m_if.tdata, 32'd5);
    m_if.tready = 1'b1;
    step();
    idle();
    check_eq("t3_new6", m_if.tdata, 32'd6);
    check_eq("t3_valid6", {31'd0, m_if.tvalid}, 32'd1);
    check_eq("t3_sts1", sts_blocks, 32'd1);
    step();
    check_eq("t3_drained", {31'd0, m_if.tvalid}, 32'd0);
    check_eq("t3_sts2", sts_blocks, 32'd2);

    // 4: cfg change mid-block takes effect only on the next block.
    do_reset();
    cfg_log2n = 4'd2;
    send(32'd1); send(32'd2);
    cfg_log2n = 4'd0;
    send(32'd3);
    check_eq("t4_not_closed", {31'd0, m_if.tvalid}, 32'd0);
    send(32'd4);
    check_eq("t4_mean", m_if.tdata, 32'd2);
    send(32'd7);
    idle();
    check_eq("t4_pass", m_if.tdata, 32'd7);
    check_eq("t4_pass_valid", {31'd0, m_if.tvalid}, 32'd1);
    step();

    // 5: n=10 extremes are exact; full rate means no stalls.
    cfg_log2n = 4'd10;
    fullrate  = 1'b1;
    for (int i = 0; i < 1024; i++) send(32'h7FFF_FFFF);
    check_eq("t5_max", m_if.tdata, 32'h7FFF_FFFF);
    for (int i = 0; i < 1024; i++) send(32'h8000_0000);
    idle();
    fullrate = 1'b0;
    check_eq("t5_min", m_if.tdata, 32'h8000_0000);
    check_eq("t5_stalls", 32'(stalls), 32'd0);
    step();

    // 6: reset mid-block zeroes outputs at once and drops the partial block.
    cfg_log2n = 4'd2;
    send(32'd1); send(32'd2); send(32'd3);
    idle();
    #3 areset = 1'b1;
    #1;
    check_eq("t6_tdata", m_if.tdata, 32'd0);
    check_eq("t6_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check_eq("t6_sts", sts_blocks, 32'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    send(32'd8); send(32'd8); send(32'd8);
    check_eq("t6_no_stale", {31'd0, m_if.tvalid}, 32'd0);
    send(32'd8);
    idle();
    check_eq("t6_mean", m_if.tdata, 32'd8);
    step();

    // 7: cfg above the maximum clamps to 1024-sample blocks.
    cfg_log2n = 4'd12;
    for (int i = 0; i < 1024; i++) send(32'hFFFF_FFFB);
    idle();
    check_eq("t7_clamp_valid", {31'd0, m_if.tvalid}, 32'd1);
    check_eq("t7_clamp_mean", m_if.tdata, 32'hFFFF_FFFB);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("final_sts", sts_blocks, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
